// File: rtl/alu_share_ctrl.sv
// Round-robin front end that time-shares one combinational ALU between two requesters.
// Each accepted op drives the ALU for a fixed opcode-dependent cycle count, then holds the result for the owner.
module alu_share_ctrl #(
   parameter int WIDTH        = 32,
   parameter int SHORT_CYCLES = 1,
   parameter int LONG_CYCLES  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [5:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [5:0]       req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic [3:0]       rsp0_flags,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic [3:0]       rsp1_flags,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [5:0]       alu_ctrl,
   output logic             alu_valid,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   input  logic             alu_carry,
   input  logic             alu_negative,
   output logic             busy
);

   localparam logic [5:0] OP_MULT   = 6'h18;
   localparam logic [5:0] OP_DIV    = 6'h1A;
   localparam logic [5:0] OP_REMDER = 6'h1B;

   localparam int MAX_CYCLES = (LONG_CYCLES > SHORT_CYCLES) ? LONG_CYCLES : SHORT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic is_long_op(input logic [5:0] op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_REMDER);
   endfunction

   state_t             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic               owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   alu_a_q, alu_a_d;
   logic [WIDTH-1:0]   alu_b_q, alu_b_d;
   logic [5:0]         alu_ctrl_q, alu_ctrl_d;
   logic               alu_valid_q, alu_valid_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [3:0]         flags_q, flags_d;
   logic [1:0]         rsp_valid_q, rsp_valid_d;
   logic               busy_q, busy_d;

   logic               grant_s;
   logic               idle_s;
   logic               accept_s;
   logic               rsp_ready_s;
   logic [WIDTH-1:0]   sel_a_s;
   logic [WIDTH-1:0]   sel_b_s;
   logic [5:0]         sel_op_s;

   // On a tie the requester that did not win last time is granted.
   assign grant_s     = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
   assign idle_s      = (state_q == ST_IDLE) && !rst;
   assign req0_ready  = idle_s && req0_valid && !grant_s;
   assign req1_ready  = idle_s && req1_valid && grant_s;
   assign accept_s    = req0_ready || req1_ready;
   assign sel_a_s     = grant_s ? req1_a  : req0_a;
   assign sel_b_s     = grant_s ? req1_b  : req0_b;
   assign sel_op_s    = grant_s ? req1_op : req0_op;
   assign rsp_ready_s = owner_q ? rsp1_ready : rsp0_ready;

   // Next-state and next-output computation for the arbitration/execute/response FSM.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      alu_valid_d  = alu_valid_q;
      result_d     = result_q;
      flags_d      = flags_q;
      rsp_valid_d  = rsp_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               owner_d      = grant_s;
               last_grant_d = grant_s;
               alu_a_d      = sel_a_s;
               alu_b_d      = sel_b_s;
               alu_ctrl_d   = sel_op_s;
               alu_valid_d  = 1'b1;
               cnt_d        = is_long_op(sel_op_s) ? LONG_LOAD : SHORT_LOAD;
               state_d      = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (cnt_q == '0) begin
               result_d    = alu_result;
               flags_d     = {alu_zero, alu_overflow, alu_carry, alu_negative};
               rsp_valid_d = owner_q ? 2'b10 : 2'b01;
               alu_a_d     = '0;
               alu_b_d     = '0;
               alu_ctrl_d  = 6'd0;
               alu_valid_d = 1'b0;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready_s) begin
               rsp_valid_d = 2'b00;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            rsp_valid_d = 2'b00;
            alu_a_d     = '0;
            alu_b_d     = '0;
            alu_ctrl_d  = 6'd0;
            alu_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= 6'd0;
         alu_valid_q  <= 1'b0;
         result_q     <= '0;
         flags_q      <= 4'd0;
         rsp_valid_q  <= 2'b00;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         alu_valid_q  <= alu_valid_d;
         result_q     <= result_d;
         flags_q      <= flags_d;
         rsp_valid_q  <= rsp_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_ctrl    = alu_ctrl_q;
   assign alu_valid   = alu_valid_q;
   assign busy        = busy_q;
   assign rsp0_valid  = rsp_valid_q[0];
   assign rsp1_valid  = rsp_valid_q[1];
   assign rsp0_result = rsp_valid_q[0] ? result_q : '0;
   assign rsp1_result = rsp_valid_q[1] ? result_q : '0;
   assign rsp0_flags  = rsp_valid_q[0] ? flags_q  : 4'd0;
   assign rsp1_flags  = rsp_valid_q[1] ? flags_q  : 4'd0;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU stub driven by the controller.
module tb_alu_share_ctrl;

   localparam logic [5:0] OP_ADD    = 6'h20;
   localparam logic [5:0] OP_SUB    = 6'h22;
   localparam logic [5:0] OP_AND    = 6'h24;
   localparam logic [5:0] OP_OR     = 6'h25;
   localparam logic [5:0] OP_XOR    = 6'h26;
   localparam logic [5:0] OP_SLT    = 6'h2A;
   localparam logic [5:0] OP_MULT   = 6'h18;
   localparam logic [5:0] OP_DIV    = 6'h1A;
   localparam logic [5:0] OP_REMDER = 6'h1B;
   localparam logic [5:0] OP_BAD    = 6'h3F;

   logic        clk;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [5:0]  req0_op, req1_op;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_result, rsp1_result;
   logic [3:0]  rsp0_flags, rsp1_flags;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [5:0]  alu_ctrl;
   logic        alu_valid, alu_zero, alu_overflow, alu_carry, alu_negative;
   logic        busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          port;
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flags;
      int          cyc;
   } vec_t;

   vec_t vecs[9];

   alu_share_ctrl #(.WIDTH(32), .SHORT_CYCLES(1), .LONG_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_valid(alu_valid),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .alu_carry(alu_carry), .alu_negative(alu_negative), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [32:0] wide_s;
   logic [63:0] prod_s;

   // Behavioural combinational ALU; division by zero gives all ones, remainder by zero gives a.
   always_comb begin
      wide_s       = 33'd0;
      prod_s       = 64'd0;
      alu_result   = 32'd0;
      alu_carry    = 1'b0;
      alu_overflow = 1'b0;
      case (alu_ctrl)
         OP_ADD: begin
            wide_s       = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result   = wide_s[31:0];
            alu_carry    = wide_s[32];
            alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
         end
         OP_SUB: begin
            wide_s       = {1'b0, alu_a} - {1'b0, alu_b};
            alu_result   = wide_s[31:0];
            alu_carry    = wide_s[32];
            alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
         end
         OP_AND:    alu_result = alu_a & alu_b;
         OP_OR:     alu_result = alu_a | alu_b;
         OP_XOR:    alu_result = alu_a ^ alu_b;
         OP_SLT:    alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
         OP_MULT: begin
            prod_s     = {32'd0, alu_a} * {32'd0, alu_b};
            alu_result = prod_s[31:0];
         end
         OP_DIV:    alu_result = (alu_b == 32'd0) ? 32'hFFFF_FFFF : alu_a / alu_b;
         OP_REMDER: alu_result = (alu_b == 32'd0) ? alu_a : alu_a % alu_b;
         default:   alu_result = 32'd0;
      endcase
      alu_zero     = (alu_result == 32'd0);
      alu_negative = alu_result[31];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one op on port p with its response channel held ready; returns result, flags, EXEC length.
   task automatic do_op(input bit p, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [3:0] flg, output int exec_cyc);
      int n;
      bit stable;
      res = 32'd0; flg = 4'd0; exec_cyc = 0; n = 0; stable = 1'b1;
      if (p) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
      else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
      #1;
      while (!(p ? req1_ready : req0_ready) && n < 20) begin tick(); n++; end
      check("accept", {63'd0, (p ? req1_ready : req0_ready)}, 64'd1);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 32'hDEAD_BEEF; req1_a = 32'hDEAD_BEEF; req0_op = OP_SUB; req1_op = OP_SUB;
      while (alu_valid && exec_cyc < 20) begin
         if (alu_a !== a || alu_b !== b || alu_ctrl !== op) stable = 1'b0;
         exec_cyc++;
         tick();
      end
      check("alu_drive_stable", {63'd0, stable}, 64'd1);
      check("rsp_owner_valid", {62'd0, rsp1_valid, rsp0_valid}, p ? 64'd2 : 64'd1);
      check("alu_idle_zero", {26'd0, alu_ctrl, alu_a}, 64'd0);
      res = p ? rsp1_result : rsp0_result;
      flg = p ? rsp1_flags  : rsp0_flags;
      tick();
      check("post_handshake", {31'd0, busy, rsp0_valid, rsp1_valid, rsp0_result}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] res;
      logic [3:0]  flg;
      int          cyc;
      int          n;
      bit          hold_ok;
      bit          seen;
      int          grants[$];
      int          rchan[$];
      logic [31:0] rres[$];

      vecs[0] = '{1'b0, OP_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, 1};
      vecs[1] = '{1'b1, OP_DIV,    32'd100,       32'd7,         32'd14,        4'b0000, 4};
      vecs[2] = '{1'b1, OP_REMDER, 32'd100,       32'd7,         32'd2,         4'b0000, 4};
      vecs[3] = '{1'b1, OP_DIV,    32'd100,       32'd0,         32'hFFFF_FFFF, 4'b0001, 4};
      vecs[4] = '{1'b0, OP_SUB,    32'd5,         32'd5,         32'd0,         4'b1000, 1};
      vecs[5] = '{1'b0, OP_MULT,   32'd3,         32'd5,         32'd15,        4'b0000, 4};
      vecs[6] = '{1'b1, OP_ADD,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010, 1};
      vecs[7] = '{1'b0, OP_BAD,    32'd123,       32'd4,         32'd0,         4'b1000, 1};
      vecs[8] = '{1'b1, OP_AND,    32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1};

      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_a = 32'd0; req0_b = 32'd0; req0_op = OP_ADD;
      req1_a = 32'd0; req1_b = 32'd0; req1_op = OP_ADD;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (2) tick();
      check("rst_busy_alu", {62'd0, busy, alu_valid}, 64'd0);
      check("rst_alu_bus", {alu_a, alu_b}, 64'd0);
      check("rst_alu_ctrl", {58'd0, alu_ctrl}, 64'd0);
      check("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
      check("rst_rsp", {26'd0, rsp0_valid, rsp1_valid, rsp0_flags, rsp0_result}, 64'd0);
      req0_valid = 1'b0;
      rst = 1'b0;
      tick();
      check("idle_after_rst", {63'd0, busy}, 64'd0);

      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, res, flg, cyc);
         check($sformatf("vec%0d_result", i), {32'd0, res}, {32'd0, vecs[i].res});
         check($sformatf("vec%0d_flags", i), {60'd0, flg}, {60'd0, vecs[i].flags});
         check($sformatf("vec%0d_exec", i), 64'(cyc), 64'(vecs[i].cyc));
      end

      // Round robin with both requesters continuously valid; last grant was port 1.
      req0_a = 32'd10; req0_b = 32'd20; req0_op = OP_ADD;
      req1_a = 32'd50; req1_b = 32'd8;  req1_op = OP_SUB;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n = 0;
      while ((grants.size() < 4 || rchan.size() < 4) && n < 80) begin
         if (req0_ready || req1_ready)
            check("rr_single_ready", {62'd0, req0_ready, req1_ready}, req0_ready ? 64'd2 : 64'd1);
         if (req0_ready) grants.push_back(0);
         else if (req1_ready) grants.push_back(1);
         if (rsp0_valid) begin
            rchan.push_back(0); rres.push_back(rsp0_result);
            check("rr_rsp_exclusive", {63'd0, rsp1_valid}, 64'd0);
         end else if (rsp1_valid) begin
            rchan.push_back(1); rres.push_back(rsp1_result);
         end
         tick();
         n++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("rr_grant_count", 64'(grants.size()), 64'd4);
      check("rr_rsp_count", 64'(rchan.size()), 64'd4);
      for (int i = 0; i < grants.size(); i++) check($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % 2));
      for (int i = 0; i < rchan.size(); i++) begin
         check($sformatf("rr_chan%0d", i), 64'(rchan[i]), 64'(i % 2));
         check($sformatf("rr_res%0d", i), {32'd0, rres[i]}, (i % 2) ? 64'd42 : 64'd30);
      end
      tick();

      // Backpressure on rsp0 while req1 waits.
      req0_a = 32'd1; req0_b = 32'd2; req0_op = OP_ADD;
      req1_a = 32'hF0; req1_b = 32'h0F; req1_op = OP_XOR;
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("bp_tie_grant", {62'd0, req0_ready, req1_ready}, 64'd2);
      tick();
      req0_valid = 1'b0;
      n = 0;
      while (!rsp0_valid && n < 20) begin tick(); n++; end
      hold_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd3 || req1_ready !== 1'b0 || rsp1_valid !== 1'b0)
            hold_ok = 1'b0;
         tick();
      end
      check("bp_hold", {63'd0, hold_ok}, 64'd1);
      rsp0_ready = 1'b1;
      #1;
      check("bp_no_accept_in_handshake", {62'd0, rsp0_valid, req1_ready}, 64'd2);
      tick();
      check("bp_accept_after", {62'd0, rsp0_valid, req1_ready}, 64'd1);
      tick();
      req1_valid = 1'b0;
      n = 0;
      while (!rsp1_valid && n < 20) begin tick(); n++; end
      check("bp_req1_result", {32'd0, rsp1_result}, 64'hFF);
      tick();

      // Reset in the middle of a long op.
      req0_a = 32'd3; req0_b = 32'd5; req0_op = OP_MULT; req0_valid = 1'b1;
      #1;
      n = 0;
      while (!req0_ready && n < 20) begin tick(); n++; end
      tick();
      req0_valid = 1'b0;
      check("mid_exec_valid", {63'd0, alu_valid}, 64'd1);
      tick();
      rst = 1'b1;
      tick();
      check("mid_rst_cleared", {61'd0, busy, alu_valid, rsp0_valid}, 64'd0);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         seen = seen | rsp0_valid | rsp1_valid;
         tick();
      end
      check("mid_rst_no_rsp", {63'd0, seen}, 64'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("post_rst_tie", {62'd0, req0_ready, req1_ready}, 64'd2);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      do_op(1'b0, OP_ADD, 32'd2, 32'd3, res, flg, cyc);
      check("post_rst_result", {32'd0, res}, 64'd5);
      check("post_rst_exec", 64'(cyc), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
